milestone_sequencer: RTL and testbench

//  Parametrised sequencer/arbiter for the image-decode milestones: launches NUM_STAGES milestone units in order via start/done

---
 rtl/milestone_seq_pkg.sv | 16 +
 rtl/milestone_sequencer_mult_bank.sv | 44 ++++
 rtl/milestone_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_milestone_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/milestone_seq_pkg.sv
// Shared types and constants for the milestone sequencer.
// Build option MILESTONE_SEQ_MULT_PIPE_EN (see mult_bank) registers the multiplier bank outputs.
package milestone_seq_pkg;

  typedef enum logic [2:0] {
    S_SEQ_IDLE,
    S_SEQ_SELECT,
    S_SEQ_RUN,
    S_SEQ_GAP,
    S_SEQ_FINISH
  } seq_state_t;

  localparam int GAP_CYCLES = 1;
  localparam int GAP_CNT_W  = 8;

endpackage

// File: rtl/milestone_sequencer_mult_bank.sv
// Bank of NUM_MULT unsigned MULT_W x MULT_W multipliers shared by the milestone stages.
// With MILESTONE_SEQ_MULT_PIPE_EN defined the products are registered (one cycle latency).
module mult_bank #(
  parameter int NUM_MULT = 3,
  parameter int MULT_W   = 32
) (
`ifdef MILESTONE_SEQ_MULT_PIPE_EN
  input  logic                         CLOCK_50_I,
  input  logic                         resetn,
`endif
  input  logic [NUM_MULT*MULT_W-1:0]   op_a_i,
  input  logic [NUM_MULT*MULT_W-1:0]   op_b_i,
  output logic [NUM_MULT*2*MULT_W-1:0] res_o
);

  logic [NUM_MULT*2*MULT_W-1:0] prod_d;

  // Zero-extend both operands so the full 2*MULT_W product is kept.
  always_comb begin
    prod_d = '0;
    for (int j = 0; j < NUM_MULT; j++) begin
      prod_d[j*2*MULT_W +: 2*MULT_W] =
        {{MULT_W{1'b0}}, op_a_i[j*MULT_W +: MULT_W]} *
        {{MULT_W{1'b0}}, op_b_i[j*MULT_W +: MULT_W]};
    end
  end

`ifdef MILESTONE_SEQ_MULT_PIPE_EN
  logic [NUM_MULT*2*MULT_W-1:0] prod_q;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign res_o = prod_q;
`else
  assign res_o = prod_d;
`endif

endmodule

// File: rtl/milestone_sequencer.sv
// Sequences the milestone units in order and grants SRAM and the multiplier bank to the active one.
// Honours MILESTONE_SEQ_MULT_PIPE_EN through the mult_bank instance.
module milestone_sequencer
  import milestone_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_MULT   = 3,
  parameter int MULT_W     = 32,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int WDOG_W     = 26,
  localparam int SEL_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                                CLOCK_50_I,
  input  logic                                resetn,
  input  logic                                go,
  input  logic                                abort,
  input  logic [NUM_STAGES-1:0]               stage_mask,
  output logic                                busy,
  output logic                                seq_done,
  output logic [SEL_W-1:0]                    cur_stage,
  output logic [NUM_STAGES-1:0]               wdog_err,
  output logic [NUM_STAGES-1:0]               stage_start,
  input  logic [NUM_STAGES-1:0]               stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0]        stage_sram_addr,
  input  logic [NUM_STAGES*DATA_W-1:0]        stage_sram_wdata,
  input  logic [NUM_STAGES-1:0]               stage_sram_we_n,
  input  logic [NUM_STAGES*NUM_MULT*MULT_W-1:0] stage_mult_a,
  input  logic [NUM_STAGES*NUM_MULT*MULT_W-1:0] stage_mult_b,
  output logic [NUM_MULT*2*MULT_W-1:0]        mult_res,
  input  logic [ADDR_W-1:0]                   dflt_sram_addr,
  input  logic [DATA_W-1:0]                   dflt_sram_wdata,
  input  logic                                dflt_sram_we_n,
  output logic [ADDR_W-1:0]                   sram_addr,
  output logic [DATA_W-1:0]                   sram_wdata,
  output logic                                sram_we_n
);

  localparam logic [WDOG_W-1:0]    WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
  localparam logic [GAP_CNT_W-1:0] GAP_LAST  = GAP_CNT_W'(GAP_CYCLES - 1);

  seq_state_t                state_q;
  logic                      busy_q;
  logic                      seq_done_q;
  logic [SEL_W-1:0]          cur_stage_q;
  logic [NUM_STAGES-1:0]     wdog_err_q;
  logic [NUM_STAGES-1:0]     stage_start_q;
  logic [NUM_STAGES-1:0]     mask_q;
  logic [WDOG_W-1:0]         wdog_q;
  logic [GAP_CNT_W-1:0]      gap_cnt_q;

  logic [SEL_W-1:0]          next_stage_d;
  logic [NUM_STAGES-1:0]     next_onehot_d;
  logic                      cur_done_d;

  logic [NUM_MULT*MULT_W-1:0] op_a_d;
  logic [NUM_MULT*MULT_W-1:0] op_b_d;

  // Lowest pending stage wins; scanning downwards lets the lowest index overwrite.
  always_comb begin
    next_stage_d  = '0;
    next_onehot_d = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        next_stage_d     = SEL_W'(i);
        next_onehot_d    = '0;
        next_onehot_d[i] = 1'b1;
      end
    end
  end

  // stage_start_q is one-hot on the running stage, so it doubles as the done selector.
  assign cur_done_d = |(stage_done & stage_start_q);

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_SEQ_IDLE;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
      cur_stage_q   <= '0;
      wdog_err_q    <= '0;
      stage_start_q <= '0;
      mask_q        <= '0;
      wdog_q        <= '0;
      gap_cnt_q     <= '0;
    end else begin
      seq_done_q <= 1'b0;
      if (abort && (state_q != S_SEQ_IDLE)) begin
        state_q       <= S_SEQ_IDLE;
        busy_q        <= 1'b0;
        cur_stage_q   <= '0;
        stage_start_q <= '0;
        mask_q        <= '0;
        wdog_q        <= '0;
        gap_cnt_q     <= '0;
      end else begin
        case (state_q)
          S_SEQ_IDLE: begin
            if (go) begin
              mask_q     <= stage_mask;
              wdog_err_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_SEQ_SELECT;
            end
          end
          S_SEQ_SELECT: begin
            if (|mask_q) begin
              cur_stage_q   <= next_stage_d;
              mask_q        <= mask_q & ~next_onehot_d;
              stage_start_q <= next_onehot_d;
              wdog_q        <= '0;
              state_q       <= S_SEQ_RUN;
            end else begin
              seq_done_q <= 1'b1;
              state_q    <= S_SEQ_FINISH;
            end
          end
          S_SEQ_RUN: begin
            if (cur_done_d) begin
              stage_start_q <= '0;
              gap_cnt_q     <= '0;
              state_q       <= S_SEQ_GAP;
            end else if (wdog_q == WDOG_LAST) begin
              // Counter would reach its maximum this edge: give up on the stage.
              wdog_err_q    <= wdog_err_q | stage_start_q;
              stage_start_q <= '0;
              gap_cnt_q     <= '0;
              state_q       <= S_SEQ_GAP;
            end else begin
              wdog_q <= wdog_q + 1'b1;
            end
          end
          S_SEQ_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= S_SEQ_SELECT;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
          S_SEQ_FINISH: begin
            busy_q      <= 1'b0;
            cur_stage_q <= '0;
            state_q     <= S_SEQ_IDLE;
          end
          default: begin
            state_q <= S_SEQ_IDLE;
          end
        endcase
      end
    end
  end

  // Write enable is held inactive during handover so no owner glitches a write in.
  always_comb begin
    sram_addr  = dflt_sram_addr;
    sram_wdata = dflt_sram_wdata;
    sram_we_n  = dflt_sram_we_n;
    op_a_d     = '0;
    op_b_d     = '0;
    case (state_q)
      S_SEQ_RUN, S_SEQ_GAP: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (cur_stage_q == SEL_W'(i)) begin
            sram_addr  = stage_sram_addr[i*ADDR_W +: ADDR_W];
            sram_wdata = stage_sram_wdata[i*DATA_W +: DATA_W];
            sram_we_n  = stage_sram_we_n[i];
            op_a_d     = stage_mult_a[i*NUM_MULT*MULT_W +: NUM_MULT*MULT_W];
            op_b_d     = stage_mult_b[i*NUM_MULT*MULT_W +: NUM_MULT*MULT_W];
          end
        end
      end
      S_SEQ_SELECT, S_SEQ_FINISH: begin
        sram_we_n = 1'b1;
      end
      default: begin
      end
    endcase
  end

  mult_bank #(
    .NUM_MULT (NUM_MULT),
    .MULT_W   (MULT_W)
  ) u_mult_bank (
`ifdef MILESTONE_SEQ_MULT_PIPE_EN
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
`endif
    .op_a_i     (op_a_d),
    .op_b_i     (op_b_d),
    .res_o      (mult_res)
  );

  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign cur_stage   = cur_stage_q;
  assign wdog_err    = wdog_err_q;
  assign stage_start = stage_start_q;

endmodule

// File: tb/tb_milestone_sequencer.sv
// Directed self-checking bench for milestone_sequencer (3 stages, WDOG_W=4).
// Latency of mult_res checks follows MILESTONE_SEQ_MULT_PIPE_EN.
module tb_milestone_sequencer;

  localparam int NS = 3;
  localparam int NM = 3;
  localparam int MW = 32;
  localparam int AW = 18;
  localparam int DW = 16;

  logic                  clock = 1'b0;
  logic                  resetn;
  logic                  go;
  logic                  abort;
  logic [NS-1:0]         stage_mask;
  logic                  busy;
  logic                  seq_done;
  logic [1:0]            cur_stage;
  logic [NS-1:0]         wdog_err;
  logic [NS-1:0]         stage_start;
  logic [NS-1:0]         stage_done;
  logic [NS*AW-1:0]      stage_sram_addr;
  logic [NS*DW-1:0]      stage_sram_wdata;
  logic [NS-1:0]         stage_sram_we_n;
  logic [NS*NM*MW-1:0]   stage_mult_a;
  logic [NS*NM*MW-1:0]   stage_mult_b;
  logic [NM*2*MW-1:0]    mult_res;
  logic [AW-1:0]         dflt_sram_addr;
  logic [DW-1:0]         dflt_sram_wdata;
  logic                  dflt_sram_we_n;
  logic [AW-1:0]         sram_addr;
  logic [DW-1:0]         sram_wdata;
  logic                  sram_we_n;

  int checks = 0;
  int errors = 0;
  int done_delay [NS];
  int run_cnt    [NS];

  localparam logic [AW-1:0] DFLT_ADDR = 18'h3FF00;
  localparam logic [NM*2*MW-1:0] MULT_EXP =
    {64'h0000_0000_0000_002A, 64'h0000_0001_0000_0000, 64'h0000_0001_FFFF_FFFE};

  milestone_sequencer #(
    .NUM_STAGES (NS), .NUM_MULT (NM), .MULT_W (MW),
    .ADDR_W (AW), .DATA_W (DW), .WDOG_W (4)
  ) dut (
    .CLOCK_50_I       (clock),
    .resetn           (resetn),
    .go               (go),
    .abort            (abort),
    .stage_mask       (stage_mask),
    .busy             (busy),
    .seq_done         (seq_done),
    .cur_stage        (cur_stage),
    .wdog_err         (wdog_err),
    .stage_start      (stage_start),
    .stage_done       (stage_done),
    .stage_sram_addr  (stage_sram_addr),
    .stage_sram_wdata (stage_sram_wdata),
    .stage_sram_we_n  (stage_sram_we_n),
    .stage_mult_a     (stage_mult_a),
    .stage_mult_b     (stage_mult_b),
    .mult_res         (mult_res),
    .dflt_sram_addr   (dflt_sram_addr),
    .dflt_sram_wdata  (dflt_sram_wdata),
    .dflt_sram_we_n   (dflt_sram_we_n),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .sram_we_n        (sram_we_n)
  );

  always #5 clock = ~clock;

  // Milestone stand-ins: raise done after done_delay start cycles (0 = never), drop it with start.
  always begin
    @(posedge clock);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (stage_start[i]) begin
        run_cnt[i]++;
        if (done_delay[i] != 0 && run_cnt[i] >= done_delay[i]) stage_done[i] = 1'b1;
      end else begin
        run_cnt[i]    = 0;
        stage_done[i] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 ns after the edge that accepted go (cycle k=1).
  task automatic start_go(input logic [NS-1:0] mask);
    @(posedge clock);
    #1;
    go = 1'b1;
    stage_mask = mask;
    step();
    go = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2);
    done_delay[0] = d0;
    done_delay[1] = d1;
    done_delay[2] = d2;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++;
    if ({busy, seq_done, cur_stage, wdog_err, stage_start} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b cur=%0d wdog=%b start=%b want all 0",
               busy, seq_done, cur_stage, wdog_err, stage_start);
    end
    checks++;
    if (sram_addr !== DFLT_ADDR || sram_we_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_sram got addr=%h we_n=%b want %h 0", sram_addr, sram_we_n, DFLT_ADDR);
    end
    checks++;
    if (mult_res !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mult got %h want 0", mult_res);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_full_sequence();
    logic [NS-1:0] exp_start;
    set_delays(10, 10, 10);
    start_go(3'b111);
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) step();
      exp_start = (k >= 2  && k <= 11) ? 3'b001 :
                  (k >= 14 && k <= 23) ? 3'b010 :
                  (k >= 26 && k <= 35) ? 3'b100 : 3'b000;
      checks++;
      if (stage_start !== exp_start) begin
        errors++;
        $display("[TB] FAIL full_start k=%0d got %b want %b", k, stage_start, exp_start);
      end
      checks++;
      if (seq_done !== (k == 38) || busy !== (k <= 38)) begin
        errors++;
        $display("[TB] FAIL full_done_busy k=%0d got done=%b busy=%b want %b %b",
                 k, seq_done, busy, (k == 38), (k <= 38));
      end
      if (k == 15) begin
        checks++;
        if (cur_stage !== 2'd1 || sram_addr !== 18'h0BEEF) begin
          errors++;
          $display("[TB] FAIL full_grant1 got cur=%0d addr=%h want 1 0beef", cur_stage, sram_addr);
        end
      end
    end
  endtask

  task automatic test_sparse_mask();
    logic [NS-1:0] exp_start;
    set_delays(3, 3, 3);
    checks++;
    if (sram_we_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sparse_idle_we got %b want 0", sram_we_n);
    end
    start_go(3'b101);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) step();
      exp_start = (k >= 2 && k <= 4) ? 3'b001 : (k >= 7 && k <= 9) ? 3'b100 : 3'b000;
      checks++;
      if (stage_start !== exp_start || seq_done !== (k == 12)) begin
        errors++;
        $display("[TB] FAIL sparse_seq k=%0d got start=%b done=%b want %b %b",
                 k, stage_start, seq_done, exp_start, (k == 12));
      end
      if (k == 1) begin
        checks++;
        if (sram_we_n !== 1'b1) begin
          errors++;
          $display("[TB] FAIL sparse_select_we got %b want 1", sram_we_n);
        end
      end
      if (k == 3) begin
        checks++;
        if (cur_stage !== 2'd0 || sram_addr !== 18'h00ABC || sram_we_n !== 1'b0) begin
          errors++;
          $display("[TB] FAIL sparse_grant0 got cur=%0d addr=%h we=%b want 0 00abc 0", cur_stage, sram_addr, sram_we_n);
        end
      end
      if (k == 8) begin
        checks++;
        if (cur_stage !== 2'd2 || sram_addr !== 18'h12345) begin
          errors++;
          $display("[TB] FAIL sparse_grant2 got cur=%0d addr=%h want 2 12345", cur_stage, sram_addr);
        end
      end
    end
  endtask

  task automatic test_empty_mask();
    start_go(3'b000);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      checks++;
      if (stage_start !== 3'b000 || sram_addr !== DFLT_ADDR || seq_done !== (k == 2) || busy !== (k <= 2)) begin
        errors++;
        $display("[TB] FAIL empty k=%0d got start=%b addr=%h done=%b busy=%b want 000 %h %b %b",
                 k, stage_start, sram_addr, seq_done, busy, DFLT_ADDR, (k == 2), (k <= 2));
      end
    end
  endtask

  task automatic test_watchdog();
    int cnt1 = 0;
    int cnt2 = 0;
    set_delays(3, 0, 3);
    start_go(3'b111);
    for (int k = 1; k <= 31; k++) begin
      if (k > 1) step();
      if (stage_start[1]) cnt1++;
      if (stage_start[2]) cnt2++;
      if (k == 21 || k == 22) begin
        checks++;
        if (wdog_err !== ((k == 22) ? 3'b010 : 3'b000)) begin
          errors++;
          $display("[TB] FAIL wdog_flag k=%0d got %b want %b", k, wdog_err, (k == 22) ? 3'b010 : 3'b000);
        end
      end
      checks++;
      if (seq_done !== (k == 29)) begin
        errors++;
        $display("[TB] FAIL wdog_seq_done k=%0d got %b want %b", k, seq_done, (k == 29));
      end
    end
    checks++;
    if (cnt1 != 15 || cnt2 != 3 || wdog_err !== 3'b010 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wdog_summary got run1=%0d run2=%0d wdog=%b busy=%b want 15 3 010 0",
               cnt1, cnt2, wdog_err, busy);
    end
  endtask

  task automatic test_abort();
    set_delays(3, 3, 3);
    start_go(3'b111);
    checks++;
    if (wdog_err !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_go_clear got wdog=%b busy=%b want 000 1", wdog_err, busy);
    end
    step();
    step();
    step();
    do_abort();
    checks++;
    if (stage_start !== 3'b000 || busy !== 1'b0 || seq_done !== 1'b0 || cur_stage !== 2'd0) begin
      errors++;
      $display("[TB] FAIL abort_with_done got start=%b busy=%b done=%b cur=%0d want 000 0 0 0",
               stage_start, busy, seq_done, cur_stage);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (seq_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_quiet got done=%b busy=%b want 0 0", seq_done, busy);
      end
    end
    start_go(3'b111);
    step();
    checks++;
    if (stage_start !== 3'b001 || cur_stage !== 2'd0) begin
      errors++;
      $display("[TB] FAIL abort_restart got start=%b cur=%0d want 001 0", stage_start, cur_stage);
    end
    do_abort();
  endtask

  task automatic test_abort_go_idle();
    @(posedge clock);
    #1;
    go = 1'b1;
    abort = 1'b1;
    stage_mask = 3'b001;
    step();
    go = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_go_idle_busy got %b want 1", busy);
    end
    step();
    checks++;
    if (stage_start !== 3'b001) begin
      errors++;
      $display("[TB] FAIL abort_go_idle_start got %b want 001", stage_start);
    end
    do_abort();
  endtask

  task automatic test_mult();
    logic [NM*2*MW-1:0] exp_k2;
    set_delays(0, 0, 0);
    stage_mult_a[0*MW +: MW] = 32'hFFFF_FFFF;
    stage_mult_b[0*MW +: MW] = 32'h0000_0002;
    stage_mult_a[1*MW +: MW] = 32'h0001_0000;
    stage_mult_b[1*MW +: MW] = 32'h0001_0000;
    stage_mult_a[2*MW +: MW] = 32'h0000_0007;
    stage_mult_b[2*MW +: MW] = 32'h0000_0006;
    stage_mult_a[3*MW +: MW] = 32'h0000_0003;
    stage_mult_b[3*MW +: MW] = 32'h0000_0003;
    step();
    checks++;
    if (mult_res !== '0) begin
      errors++;
      $display("[TB] FAIL mult_idle got %h want 0", mult_res);
    end
    start_go(3'b001);
    step();
`ifdef MILESTONE_SEQ_MULT_PIPE_EN
    exp_k2 = '0;
`else
    exp_k2 = MULT_EXP;
`endif
    checks++;
    if (mult_res !== exp_k2) begin
      errors++;
      $display("[TB] FAIL mult_first_run got %h want %h", mult_res, exp_k2);
    end
    step();
    checks++;
    if (mult_res !== MULT_EXP) begin
      errors++;
      $display("[TB] FAIL mult_settled got %h want %h", mult_res, MULT_EXP);
    end
    do_abort();
  endtask

  task automatic test_reset_mid_run();
    set_delays(10, 10, 10);
    start_go(3'b111);
    step();
    step();
    resetn = 1'b0;
    #1;
    checks++;
    if (stage_start !== 3'b000 || busy !== 1'b0 || cur_stage !== 2'd0 || seq_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run got start=%b busy=%b cur=%0d done=%b want 000 0 0 0",
               stage_start, busy, cur_stage, seq_done);
    end
    @(negedge clock);
    resetn = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || stage_start !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_release got busy=%b start=%b want 0 000", busy, stage_start);
    end
  endtask

  initial begin
    go = 1'b0;
    abort = 1'b0;
    stage_mask = '0;
    stage_done = '0;
    stage_sram_addr = {18'h12345, 18'h0BEEF, 18'h00ABC};
    stage_sram_wdata = {16'h2222, 16'h1111, 16'h0000};
    stage_sram_we_n = 3'b000;
    stage_mult_a = '0;
    stage_mult_b = '0;
    dflt_sram_addr = DFLT_ADDR;
    dflt_sram_wdata = 16'hD00D;
    dflt_sram_we_n = 1'b0;
    for (int i = 0; i < NS; i++) begin
      done_delay[i] = 10;
      run_cnt[i] = 0;
    end
    test_reset();
    test_full_sequence();
    test_sparse_mask();
    test_empty_mask();
    test_watchdog();
    test_abort();
    test_abort_go_idle();
    test_mult();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
